// File: rtl/ca_pkg.sv
// rtl/ca_pkg.sv - shared constants and scheduler state encoding for the CA image RAM controller
package ca_pkg;
  localparam int CA_ADDR_W  = 10;
  localparam int CA_DATA_W  = 16;
  localparam int CA_START_X = 1296;
  localparam int CA_SEED_Y  = 1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    SEED = 2'd2
  } sched_state_t;
endpackage

// File: rtl/ca_port_arb.sv
// rtl/ca_port_arb.sv - fixed-priority read/write arbiter for the image RAM with read-after-write hazard block
module ca_port_arb
  import ca_pkg::*;
#(
  parameter int ADDR_W = CA_ADDR_W,
  parameter int DATA_W = CA_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              gen_rreq,
  input  logic [ADDR_W-1:0] gen_raddr,
  input  logic              gen_wreq,
  input  logic [ADDR_W-1:0] gen_waddr,
  input  logic [DATA_W-1:0] gen_wdata,
  input  logic              seed_wreq,
  input  logic [ADDR_W-1:0] seed_waddr,
  input  logic [DATA_W-1:0] seed_wdata,
  output logic              disp_gnt,
  output logic              gen_rgnt,
  output logic              disp_rvalid,
  output logic              gen_rvalid,
  output logic              gen_wgnt,
  output logic              seed_wgnt,
  output logic              ram_ena,
  output logic [ADDR_W-1:0] ram_addra,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic [DATA_W-1:0] ram_dinb
);

  logic hazard;

  // Grants are forced low while rst is high so the RAM ports go quiet immediately.
  always_comb begin
    disp_gnt  = 1'b0;
    gen_rgnt  = 1'b0;
    gen_wgnt  = 1'b0;
    seed_wgnt = 1'b0;
    ram_ena   = 1'b0;
    ram_addra = '0;
    ram_enb   = 1'b0;
    ram_addrb = '0;
    ram_dinb  = '0;
    hazard    = 1'b0;
    if (!rst) begin
      gen_wgnt  = gen_wreq;
      seed_wgnt = seed_wreq & ~gen_wreq;
      if (gen_wgnt) begin
        ram_addrb = gen_waddr;
        ram_dinb  = gen_wdata;
      end else if (seed_wgnt) begin
        ram_addrb = seed_waddr;
        ram_dinb  = seed_wdata;
      end
      ram_enb  = gen_wgnt | seed_wgnt;
      hazard   = ram_enb && (ram_addrb == gen_raddr);
      disp_gnt = disp_req;
      gen_rgnt = gen_rreq & ~disp_req & ~hazard;
      ram_ena  = disp_gnt | gen_rgnt;
      if (disp_gnt) begin
        ram_addra = disp_addr;
      end else if (gen_rgnt) begin
        ram_addra = gen_raddr;
      end
    end
  end

  // ram_douta appears one cycle after the grant; tag it for the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_rvalid <= 1'b0;
      gen_rvalid  <= 1'b0;
    end else begin
      disp_rvalid <= disp_gnt;
      gen_rvalid  <= gen_rgnt;
    end
  end

endmodule

// File: rtl/ca_ram_sched.sv
// rtl/ca_ram_sched.sv - pass scheduler and RAM arbiter top; CA_SCHED_STATS_EN adds stall/overrun counters
module ca_ram_sched
  import ca_pkg::*;
#(
  parameter int ADDR_W  = CA_ADDR_W,
  parameter int DATA_W  = CA_DATA_W,
  parameter int START_X = CA_START_X,
  parameter int SEED_Y  = CA_SEED_Y
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       counter_x,
  input  logic [10:0]       counter_y,
  output logic              gen_start,
  output logic              seed_start,
  input  logic              gen_done,
  input  logic              seed_done,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              gen_rreq,
  input  logic [ADDR_W-1:0] gen_raddr,
  output logic              disp_gnt,
  output logic              gen_rgnt,
  output logic              disp_rvalid,
  output logic              gen_rvalid,
  input  logic              gen_wreq,
  input  logic [ADDR_W-1:0] gen_waddr,
  input  logic [DATA_W-1:0] gen_wdata,
  input  logic              seed_wreq,
  input  logic [ADDR_W-1:0] seed_waddr,
  input  logic [DATA_W-1:0] seed_wdata,
  output logic              gen_wgnt,
  output logic              seed_wgnt,
  output logic              ram_ena,
  output logic [ADDR_W-1:0] ram_addra,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic [DATA_W-1:0] ram_dinb,
  output logic              overrun
`ifdef CA_SCHED_STATS_EN
  ,
  output logic [15:0]       gen_stall_cnt,
  output logic [7:0]        overrun_cnt
`endif
);

  localparam logic [10:0] START_X_V = START_X[10:0];
  localparam logic [10:0] SEED_Y_V  = SEED_Y[10:0];

  sched_state_t state_q, state_d;
  logic gen_start_d, seed_start_d, skip;
  logic at_start, gen_line, seed_line, free;

  assign at_start  = (counter_x == START_X_V);
  assign gen_line  = (counter_y < SEED_Y_V);
  assign seed_line = (counter_y == SEED_Y_V);

  // A done arriving with a launch point frees the scheduler first.
  always_comb begin
    state_d      = state_q;
    gen_start_d  = 1'b0;
    seed_start_d = 1'b0;
    skip         = 1'b0;
    free         = 1'b0;
    case (state_q)
      IDLE: free = 1'b1;
      GEN: begin
        if (gen_done) begin
          free    = 1'b1;
          state_d = IDLE;
        end
      end
      SEED: begin
        if (seed_done) begin
          free    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        free    = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (at_start && (gen_line || seed_line)) begin
      if (!free) begin
        skip = 1'b1;
      end else if (gen_line) begin
        state_d     = GEN;
        gen_start_d = 1'b1;
      end else begin
        state_d      = SEED;
        seed_start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gen_start  <= 1'b0;
      seed_start <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gen_start  <= gen_start_d;
      seed_start <= seed_start_d;
      if (skip) begin
        overrun <= 1'b1;
      end
    end
  end

  ca_port_arb #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .gen_rreq   (gen_rreq),
    .gen_raddr  (gen_raddr),
    .gen_wreq   (gen_wreq),
    .gen_waddr  (gen_waddr),
    .gen_wdata  (gen_wdata),
    .seed_wreq  (seed_wreq),
    .seed_waddr (seed_waddr),
    .seed_wdata (seed_wdata),
    .disp_gnt   (disp_gnt),
    .gen_rgnt   (gen_rgnt),
    .disp_rvalid(disp_rvalid),
    .gen_rvalid (gen_rvalid),
    .gen_wgnt   (gen_wgnt),
    .seed_wgnt  (seed_wgnt),
    .ram_ena    (ram_ena),
    .ram_addra  (ram_addra),
    .ram_enb    (ram_enb),
    .ram_addrb  (ram_addrb),
    .ram_dinb   (ram_dinb)
  );

`ifdef CA_SCHED_STATS_EN
  logic frame_start;
  assign frame_start = (counter_x == 11'd0) && (counter_y == 11'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_stall_cnt <= '0;
      overrun_cnt   <= '0;
    end else if (frame_start) begin
      gen_stall_cnt <= '0;
      overrun_cnt   <= '0;
    end else begin
      if (gen_rreq && !gen_rgnt && gen_stall_cnt != 16'hFFFF) begin
        gen_stall_cnt <= gen_stall_cnt + 16'd1;
      end
      if (skip && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ca_ram_sched.sv
// tb/tb_ca_ram_sched.sv - directed self-checking bench for ca_ram_sched
`timescale 1ns/1ps
module tb_ca_ram_sched;
  import ca_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] counter_x, counter_y;
  logic        gen_start, seed_start, gen_done, seed_done;
  logic        disp_req, gen_rreq;
  logic [9:0]  disp_addr, gen_raddr;
  logic        disp_gnt, gen_rgnt, disp_rvalid, gen_rvalid;
  logic        gen_wreq, seed_wreq;
  logic [9:0]  gen_waddr, seed_waddr;
  logic [15:0] gen_wdata, seed_wdata;
  logic        gen_wgnt, seed_wgnt;
  logic        ram_ena, ram_enb;
  logic [9:0]  ram_addra, ram_addrb;
  logic [15:0] ram_dinb;
  logic        overrun;
`ifdef CA_SCHED_STATS_EN
  logic [15:0] gen_stall_cnt;
  logic [7:0]  overrun_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic seq_done = 1'b0;

  always #5 clk = ~clk;

  ca_ram_sched dut (
    .clk        (clk),
    .rst        (rst),
    .counter_x  (counter_x),
    .counter_y  (counter_y),
    .gen_start  (gen_start),
    .seed_start (seed_start),
    .gen_done   (gen_done),
    .seed_done  (seed_done),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .gen_rreq   (gen_rreq),
    .gen_raddr  (gen_raddr),
    .disp_gnt   (disp_gnt),
    .gen_rgnt   (gen_rgnt),
    .disp_rvalid(disp_rvalid),
    .gen_rvalid (gen_rvalid),
    .gen_wreq   (gen_wreq),
    .gen_waddr  (gen_waddr),
    .gen_wdata  (gen_wdata),
    .seed_wreq  (seed_wreq),
    .seed_waddr (seed_waddr),
    .seed_wdata (seed_wdata),
    .gen_wgnt   (gen_wgnt),
    .seed_wgnt  (seed_wgnt),
    .ram_ena    (ram_ena),
    .ram_addra  (ram_addra),
    .ram_enb    (ram_enb),
    .ram_addrb  (ram_addrb),
    .ram_dinb   (ram_dinb),
    .overrun    (overrun)
`ifdef CA_SCHED_STATS_EN
    ,
    .gen_stall_cnt(gen_stall_cnt),
    .overrun_cnt  (overrun_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    n_tests++;
    if (seq_done !== 1'b1) begin
      n_fail++;
      $error("FAIL watchdog: directed sequence did not complete in time");
      $finish;
    end
  end

  initial begin
    rst = 1'b1;
    counter_x = '0; counter_y = '0;
    gen_done = 1'b0; seed_done = 1'b0;
    disp_req = 1'b1; disp_addr = 10'h3;
    gen_rreq = 1'b0; gen_raddr = '0;
    gen_wreq = 1'b0; gen_waddr = '0; gen_wdata = '0;
    seed_wreq = 1'b0; seed_waddr = '0; seed_wdata = '0;
    tick;
    tick;
    n_tests++; if (gen_start !== 1'b0) begin n_fail++; $error("FAIL rst_gen_start: 0x%0h", gen_start); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $error("FAIL rst_overrun: 0x%0h", overrun); end
    n_tests++; if (disp_gnt !== 1'b0) begin n_fail++; $error("FAIL rst_disp_gnt: 0x%0h", disp_gnt); end
    n_tests++; if (ram_ena !== 1'b0) begin n_fail++; $error("FAIL rst_ram_ena: 0x%0h", ram_ena); end
    n_tests++; if (disp_rvalid !== 1'b0) begin n_fail++; $error("FAIL rst_disp_rvalid: 0x%0h", disp_rvalid); end
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $error("FAIL rst_state: 0x%0h", dut.state_q); end
    n_tests++;
    if (dut.state_q !== IDLE || gen_start !== 1'b0 || seed_start !== 1'b0 ||
        overrun !== 1'b0 || gen_rvalid !== 1'b0) begin
      n_fail++;
      $error("FAIL reset_state: state=%0d gen_start=%0b seed_start=%0b overrun=%0b gen_rvalid=%0b",
             dut.state_q, gen_start, seed_start, overrun, gen_rvalid);
    end
    disp_req = 1'b0;
    rst = 1'b0;
    tick;

    counter_x = 11'd1296; counter_y = 11'd5;
    #1;
    n_tests++; if (gen_start !== 1'b0) begin n_fail++; $error("FAIL gen_start_not_yet: 0x%0h", gen_start); end
    tick;
    n_tests++; if (gen_start !== 1'b1) begin n_fail++; $error("FAIL gen_start_l5: 0x%0h", gen_start); end
    n_tests++; if (dut.state_q !== GEN) begin n_fail++; $error("FAIL state_gen_l5: 0x%0h", dut.state_q); end
    counter_x = 11'd0;
    tick;
    n_tests++; if (gen_start !== 1'b0) begin n_fail++; $error("FAIL gen_start_one_cycle: 0x%0h", gen_start); end
    gen_done = 1'b1;
    tick;
    gen_done = 1'b0;
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $error("FAIL state_idle_after_done: 0x%0h", dut.state_q); end
    counter_x = 11'd1296; counter_y = 11'd6;
    tick;
    n_tests++; if (gen_start !== 1'b1) begin n_fail++; $error("FAIL gen_start_l6: 0x%0h", gen_start); end
    counter_x = 11'd0;
    gen_done = 1'b1;
    tick;
    gen_done = 1'b0;

    counter_x = 11'd1296; counter_y = 11'd1023;
    tick;
    n_tests++; if (seed_start !== 1'b1) begin n_fail++; $error("FAIL seed_start_l1023: 0x%0h", seed_start); end
    n_tests++; if (gen_start !== 1'b0) begin n_fail++; $error("FAIL no_gen_start_l1023: 0x%0h", gen_start); end
    n_tests++; if (dut.state_q !== SEED) begin n_fail++; $error("FAIL state_seed: 0x%0h", dut.state_q); end
    counter_x = 11'd0;
    seed_done = 1'b1;
    tick;
    seed_done = 1'b0;
    counter_x = 11'd1296; counter_y = 11'd1024;
    tick;
    n_tests++; if (gen_start !== 1'b0) begin n_fail++; $error("FAIL no_gen_l1024: 0x%0h", gen_start); end
    n_tests++; if (seed_start !== 1'b0) begin n_fail++; $error("FAIL no_seed_l1024: 0x%0h", seed_start); end
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $error("FAIL state_idle_l1024: 0x%0h", dut.state_q); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $error("FAIL no_overrun_yet: 0x%0h", overrun); end
    counter_x = 11'd0;

    counter_x = 11'd1296; counter_y = 11'd7;
    tick;
    n_tests++; if (gen_start !== 1'b1) begin n_fail++; $error("FAIL gen_start_l7: 0x%0h", gen_start); end
    counter_x = 11'd0;
    tick;
    counter_x = 11'd1296; counter_y = 11'd8;
    tick;
    n_tests++; if (gen_start !== 1'b0) begin n_fail++; $error("FAIL skip_gen_start_l8: 0x%0h", gen_start); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $error("FAIL overrun_set: 0x%0h", overrun); end
`ifdef CA_SCHED_STATS_EN
    n_tests++; if (overrun_cnt !== 8'd1) begin n_fail++; $error("FAIL overrun_cnt: 0x%0h", overrun_cnt); end
`endif
    counter_x = 11'd0;
    tick;
    counter_x = 11'd1296; counter_y = 11'd9;
    gen_done = 1'b1;
    tick;
    gen_done = 1'b0;
    counter_x = 11'd0;
    n_tests++; if (gen_start !== 1'b1) begin n_fail++; $error("FAIL done_and_launch: 0x%0h", gen_start); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $error("FAIL overrun_sticky: 0x%0h", overrun); end

    disp_req = 1'b1; disp_addr = 10'h040;
    gen_rreq = 1'b1; gen_raddr = 10'h041;
    #1;
    n_tests++; if (ram_addra !== 10'h040) begin n_fail++; $error("FAIL rd_addra_disp: 0x%0h", ram_addra); end
    n_tests++; if (disp_gnt !== 1'b1) begin n_fail++; $error("FAIL rd_disp_gnt: 0x%0h", disp_gnt); end
    n_tests++; if (gen_rgnt !== 1'b0) begin n_fail++; $error("FAIL rd_gen_rgnt_blocked: 0x%0h", gen_rgnt); end
    n_tests++; if (ram_ena !== 1'b1) begin n_fail++; $error("FAIL rd_ena: 0x%0h", ram_ena); end
    tick;
    n_tests++; if (disp_rvalid !== 1'b1) begin n_fail++; $error("FAIL rd_disp_rvalid: 0x%0h", disp_rvalid); end
    n_tests++; if (gen_rvalid !== 1'b0) begin n_fail++; $error("FAIL rd_gen_rvalid_low: 0x%0h", gen_rvalid); end
    disp_req = 1'b0;
    #1;
    n_tests++; if (gen_rgnt !== 1'b1) begin n_fail++; $error("FAIL rd_gen_rgnt: 0x%0h", gen_rgnt); end
    n_tests++; if (ram_addra !== 10'h041) begin n_fail++; $error("FAIL rd_addra_gen: 0x%0h", ram_addra); end
    tick;
    n_tests++; if (gen_rvalid !== 1'b1) begin n_fail++; $error("FAIL rd_gen_rvalid: 0x%0h", gen_rvalid); end
    n_tests++; if (disp_rvalid !== 1'b0) begin n_fail++; $error("FAIL rd_disp_rvalid_low: 0x%0h", disp_rvalid); end

    gen_raddr = 10'h010;
    gen_wreq = 1'b1; gen_waddr = 10'h010; gen_wdata = 16'h1234;
    #1;
    n_tests++; if (gen_rgnt !== 1'b0) begin n_fail++; $error("FAIL hz_gen_rgnt: 0x%0h", gen_rgnt); end
    n_tests++; if (ram_addrb !== 10'h010) begin n_fail++; $error("FAIL hz_addrb: 0x%0h", ram_addrb); end
    n_tests++; if (ram_enb !== 1'b1) begin n_fail++; $error("FAIL hz_enb: 0x%0h", ram_enb); end
    gen_wreq = 1'b0;
    #1;
    n_tests++; if (gen_rgnt !== 1'b1) begin n_fail++; $error("FAIL hz_clear_gen_rgnt: 0x%0h", gen_rgnt); end
    n_tests++; if (ram_enb !== 1'b0) begin n_fail++; $error("FAIL hz_clear_enb: 0x%0h", ram_enb); end
    n_tests++; if (ram_addrb !== 10'h000) begin n_fail++; $error("FAIL hz_clear_addrb: 0x%0h", ram_addrb); end
    gen_rreq = 1'b0;
    tick;

    gen_wreq = 1'b1; gen_waddr = 10'h020; gen_wdata = 16'hAAAA;
    seed_wreq = 1'b1; seed_waddr = 10'h030; seed_wdata = 16'h5555;
    #1;
    n_tests++; if (ram_dinb !== 16'hAAAA) begin n_fail++; $error("FAIL wr_dinb_gen: 0x%0h", ram_dinb); end
    n_tests++; if (ram_addrb !== 10'h020) begin n_fail++; $error("FAIL wr_addrb_gen: 0x%0h", ram_addrb); end
    n_tests++; if (seed_wgnt !== 1'b0) begin n_fail++; $error("FAIL wr_seed_wgnt_low: 0x%0h", seed_wgnt); end
    n_tests++; if (gen_wgnt !== 1'b1) begin n_fail++; $error("FAIL wr_gen_wgnt: 0x%0h", gen_wgnt); end
    gen_wreq = 1'b0;
    #1;
    n_tests++; if (ram_dinb !== 16'h5555) begin n_fail++; $error("FAIL wr_dinb_seed: 0x%0h", ram_dinb); end
    n_tests++; if (seed_wgnt !== 1'b1) begin n_fail++; $error("FAIL wr_seed_wgnt: 0x%0h", seed_wgnt); end
    gen_wreq = 1'b1;
    disp_req = 1'b1;

    counter_x = 11'd1296; counter_y = 11'd10;
    gen_done = 1'b1;
    tick;
    gen_done = 1'b0;
    counter_x = 11'd0;
    n_tests++; if (gen_start !== 1'b1) begin n_fail++; $error("FAIL pre_rst_gen_start: 0x%0h", gen_start); end
    n_tests++; if (disp_rvalid !== 1'b1) begin n_fail++; $error("FAIL pre_rst_disp_rvalid: 0x%0h", disp_rvalid); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (gen_start !== 1'b0) begin n_fail++; $error("FAIL arst_gen_start: 0x%0h", gen_start); end
    n_tests++; if (disp_gnt !== 1'b0) begin n_fail++; $error("FAIL arst_disp_gnt: 0x%0h", disp_gnt); end
    n_tests++; if (disp_rvalid !== 1'b0) begin n_fail++; $error("FAIL arst_disp_rvalid: 0x%0h", disp_rvalid); end
    n_tests++; if (ram_ena !== 1'b0) begin n_fail++; $error("FAIL arst_ena: 0x%0h", ram_ena); end
    n_tests++; if (ram_enb !== 1'b0) begin n_fail++; $error("FAIL arst_enb: 0x%0h", ram_enb); end
    n_tests++; if (ram_dinb !== 16'h0000) begin n_fail++; $error("FAIL arst_dinb: 0x%0h", ram_dinb); end
    n_tests++; if (ram_addrb !== 10'h000) begin n_fail++; $error("FAIL arst_addrb: 0x%0h", ram_addrb); end
    n_tests++; if (gen_wgnt !== 1'b0) begin n_fail++; $error("FAIL arst_wgnt: 0x%0h", gen_wgnt); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $error("FAIL arst_overrun: 0x%0h", overrun); end
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $error("FAIL arst_state: 0x%0h", dut.state_q); end
    gen_wreq = 1'b0; seed_wreq = 1'b0; disp_req = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    n_tests++; if (gen_start !== 1'b0) begin n_fail++; $error("FAIL post_rst_idle: 0x%0h", gen_start); end
    counter_x = 11'd1296; counter_y = 11'd11;
    tick;
    counter_x = 11'd0;
    n_tests++; if (gen_start !== 1'b1) begin n_fail++; $error("FAIL post_rst_launch: 0x%0h", gen_start); end
    n_tests++; if (dut.state_q !== GEN) begin n_fail++; $error("FAIL post_rst_state: 0x%0h", dut.state_q); end

    seq_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail != 0) begin
        $error("FAIL summary: %0d failed checks", n_fail);
    end
    $finish;
  end

endmodule
